fft_frame_loader: RTL
=====================

# fft_frame_loader

Streaming front end for the 16-point FFT datapath. It accepts one 16-bit Q15 real time-domain sample per handshake and packs 16 consecutive samples into a frame. It then presents the frame as a 16-entry parallel array with a one-cycle-registered `frame_valid_o`, in the form the FFT core's `x_re_i`/`valid_i` inputs consume. Ping-pong buffering lets the next frame be collected while the previous one is held for the consumer.

## Interface
- `SAMPLE_W`, 16, sample width in bits (Q15 signed, carried as raw bits)
- `clk_i`  input  1  single clock; all state on rising edge
- `rst_ni`  input  1  asynchronous, active-low reset
- `s_valid_i`  input  1  upstream sample valid
- `s_ready_o`  output  1  loader can accept a sample this cycle
- `s_data_i`  input  SAMPLE_W  sample value
- `s_last_i`  input  1  upstream end-of-frame marker; qualified by `s_valid_i && s_ready_o`
- `frame_valid_o`  output  1  `frame_o` holds a complete frame
- `frame_ready_i`  input  1  consumer takes the frame this cycle
- `frame_o`  output  SAMPLE_W x [0:15]  unpacked frame array; element k is sample k (see Configuration)
- `err_o`  output  1  one-cycle pulse: a frame was aborted by an early `s_last_i`
- `frames_dropped_o`  output  8  saturating count of aborted frames

## Operation
- Two buffers, A and B, each holding 16 x SAMPLE_W, plus a write-select bit, a read-select bit, a 4-bit fill index `wr_idx`, and an occupancy state.
- Occupancy FSM:
  - EMPTY: 0 full buffers.
  - ONE: 1 full buffer.
  - TWO: 2 full buffers.
  - EMPTY -> ONE on frame complete.
  - ONE -> TWO on frame complete without a frame handshake.
  - ONE -> EMPTY on a frame handshake without frame complete.
  - TWO -> ONE on a frame handshake.
  - ONE stays ONE when frame complete and frame handshake occur in the same cycle.
- Sample accept = `s_valid_i && s_ready_o`. `s_ready_o` = (state != TWO).
- On accept: write `s_data_i` into the write buffer at the mapped index of `wr_idx`, then increment `wr_idx`.
- Frame complete = accept with `wr_idx == 15`. On completion: `wr_idx` wraps to 0, write-select toggles, and occupancy increments.
- `s_last_i` on an accept with `wr_idx == 15`: normal completion.
- `s_last_i` on an accept with `wr_idx < 15` (early last):
  - The partial frame, including the current sample, is discarded.
  - `wr_idx` goes to 0; write-select is unchanged.
  - `err_o` pulses on the next cycle.
  - `frames_dropped_o` increments, saturating at 255.
- `s_last_i` low at `wr_idx == 15` is not an error.
- Frame handshake = `frame_valid_o && frame_ready_i`. On a handshake, read-select toggles.
- `frame_valid_o` = (state != EMPTY). `frame_o` always shows the read buffer.
- Buffer contents are never overwritten while they are the read buffer and state != EMPTY.

## Timing
- Reset values (asynchronous, while `rst_ni` = 0):
  - state EMPTY, `wr_idx` 0, both selects 0.
  - `frame_valid_o` 0, `err_o` 0, `frames_dropped_o` 0.
  - `s_ready_o` 1 once reset deasserts.
  - Buffer data is not reset; `frame_o` is don't-care while `frame_valid_o` = 0.
- Latency: 16th sample accepted at edge t -> `frame_valid_o` = 1 and `frame_o` valid after edge t (registered, one cycle).
- Throughput: one sample per cycle sustained when the consumer takes each frame within 16 cycles of it appearing.
- `frame_o` and `frame_valid_o` hold stable while `frame_valid_o && !frame_ready_i`.
- `s_ready_o` drops in the cycle after the second buffer completes. It rises in the cycle after the next frame handshake.
- Reset asserted mid-frame discards the partial frame and any held frames; no `err_o` is generated.

## Configuration
- `FFT_BITREV_LOAD_EN` defined: the mapped index is the 4-bit reverse of `wr_idx`, so sample n lands in `frame_o[rev4(n)]`. This gives bit-reversed input order for a decimation-in-time butterfly stage 0.
- Undefined: the mapped index is `wr_idx`, so sample n lands in `frame_o[n]` (natural order).

## Test plan
- Reset, then stream 0x0000..0x000F back-to-back with `frame_ready_i` = 1.
  - Expect `frame_valid_o` high for exactly 1 cycle, 1 cycle after the 16th accept.
  - Natural build: `frame_o[k]` = k. `FFT_BITREV_LOAD_EN` build: `frame_o[1]` = 0x0008, `frame_o[8]` = 0x0001.
- Hold `frame_ready_i` = 0 and stream 40 samples.
  - Expect `s_ready_o` low after the 32nd accept.
  - The first frame holds 0..15 stably.
  - Raise ready for 1 cycle: the second frame (16..31) is shown and `s_ready_o` returns to 1.
- Assert `s_last_i` on the 5th sample (0xAAAA).
  - Expect `err_o` pulse, `frames_dropped_o` = 1, and no `frame_valid_o`.
  - The next 16 samples form a clean frame.
- State ONE, with the 16th sample of the next frame accepted in the same cycle as a frame handshake.
  - Expect state to stay ONE, `frame_o` to switch to the new frame next cycle, and no sample lost.
- Drive `rst_ni` low mid-frame (8 samples in, 1 frame held).
  - Expect `frame_valid_o` = 0 immediately and `frames_dropped_o` = 0.
  - The next 16 samples produce a frame beginning at index 0.
- Force 300 early-last aborts: expect `frames_dropped_o` to saturate at 255.

Source files
------------

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs 16 consecutive Q15 samples into a frame and presents
// it as a parallel array for the 16-point FFT core, with ping-pong buffering so
// the next frame fills while the previous one waits for the consumer.
//
// Build option: define FFT_BITREV_LOAD_EN to store sample n at frame index
// rev4(n) (bit-reversed order for a DIT stage 0); otherwise natural order.
module fft_frame_loader #(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [SAMPLE_W-1:0] s_data_i,
    input  logic                s_last_i,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic [SAMPLE_W-1:0] frame_o [0:15],
    output logic                err_o,
    output logic [7:0]          frames_dropped_o
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Occupancy: number of complete frames currently held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   dropped_q, dropped_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;

    logic               accept_c;
    logic               handshake_c;
    logic               complete_c;
    logic               early_last_c;
    logic [IDX_W-1:0]   wr_addr_c;

    logic [SAMPLE_W-1:0] buf_a_q [0:DEPTH-1];
    logic [SAMPLE_W-1:0] buf_b_q [0:DEPTH-1];

    // Fill index to buffer slot mapping
`ifdef FFT_BITREV_LOAD_EN
    assign wr_addr_c = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2], wr_idx_q[3]};
`else
    assign wr_addr_c = wr_idx_q;
`endif

    // Transfer qualifiers for both sides
    assign accept_c     = s_valid_i && ready_q;
    assign handshake_c  = valid_q && frame_ready_i;
    assign complete_c   = accept_c && (wr_idx_q == LAST_IDX);
    assign early_last_c = accept_c && s_last_i && (wr_idx_q != LAST_IDX);

    // Next-state, pointer, error and flag logic
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        err_d     = 1'b0;
        dropped_d = dropped_q;

        if (accept_c) begin
            if (complete_c) begin
                wr_idx_d = '0;
                wr_sel_d = ~wr_sel_q;
            end else if (early_last_c) begin
                // Partial frame is abandoned in place; write buffer is reused
                wr_idx_d = '0;
            end else begin
                wr_idx_d = IDX_W'(wr_idx_q + 1'b1);
            end
        end

        if (handshake_c) begin
            rd_sel_d = ~rd_sel_q;
        end

        if (early_last_c) begin
            err_d = 1'b1;
            if (dropped_q != CNT_MAX) begin
                dropped_d = CNT_W'(dropped_q + 1'b1);
            end
        end

        unique case (state_q)
            ST_EMPTY: begin
                if (complete_c) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (complete_c && !handshake_c) begin
                    state_d = ST_TWO;
                end else if (handshake_c && !complete_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (handshake_c) begin
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    // Control and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_EMPTY;
            wr_idx_q  <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            err_q     <= 1'b0;
            dropped_q <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            err_q     <= err_d;
            dropped_q <= dropped_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    // Sample storage; never the read buffer while a frame is held
    always_ff @(posedge clk_i) begin
        if (accept_c && !wr_sel_q) begin
            buf_a_q[wr_addr_c] <= s_data_i;
        end
        if (accept_c && wr_sel_q) begin
            buf_b_q[wr_addr_c] <= s_data_i;
        end
    end

    // Present the read buffer
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            frame_o[k] = rd_sel_q ? buf_b_q[k] : buf_a_q[k];
        end
    end

    assign s_ready_o        = ready_q;
    assign frame_valid_o    = valid_q;
    assign err_o            = err_q;
    assign frames_dropped_o = dropped_q;

    // Buffer selects must track occupancy: equal when 0 or 2 held, split when 1
    a_sel_track: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_ONE) == (wr_sel_q != rd_sel_q));

    // Handshake flags mirror the occupancy state
    a_flag_track: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_q == (state_q != ST_EMPTY)) && (ready_q == (state_q != ST_TWO)));

endmodule
